// File: rtl/fir_dma_master_if.sv
// Avalon-MM-style master bus bundle used by fir_dma_master.
interface fir_dma_master_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] M_Address;
   logic              M_Read;
   logic              M_Write;
   logic [31:0]       M_WriteData;
   logic [31:0]       M_ReadData;
   logic              M_WaitRequest;

   modport master (
      output M_Address, M_Read, M_Write, M_WriteData,
      input  M_ReadData, M_WaitRequest
   );

   modport slave (
      input  M_Address, M_Read, M_Write, M_WriteData,
      output M_ReadData, M_WaitRequest
   );
endinterface

// File: rtl/fir_dma_master.sv
// Bus master streaming memory samples through the FIR slave and back to memory.
// Define FIR_DMA_IRQ_EN to add the sticky Irq output and its IrqClear input.
module fir_dma_master #(
   parameter int                ADDR_W     = 32,
   parameter int                CNT_W      = 16,
   parameter logic [ADDR_W-1:0] FIR_X_ADDR = ADDR_W'(32'h0000_1004),
   parameter logic [ADDR_W-1:0] FIR_Y_ADDR = ADDR_W'(32'h0000_1008),
   parameter int                FIR_LAT    = 1
) (
   input  logic              clk,
   input  logic              RstN,
   input  logic              Start,
   input  logic [ADDR_W-1:0] SrcAddr,
   input  logic [ADDR_W-1:0] DstAddr,
   input  logic [CNT_W-1:0]  Count,
   output logic              Busy,
   output logic              Done,
   fir_dma_master_if.master  m
`ifdef FIR_DMA_IRQ_EN
   ,
   output logic              Irq,
   input  logic              IrqClear
`endif
);

   typedef enum logic [2:0] {
      IDLE, RD_SRC, WR_X, SETTLE, RD_Y, WR_DST, DONE
   } state_e;

   localparam logic [3:0] SETTLE_LOAD = (FIR_LAT > 0) ? 4'(FIR_LAT - 1) : 4'd0;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        sample_q, sample_d;
   logic [23:0]       result_q, result_d;
   logic [3:0]        settle_q, settle_d;

   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              unused_rdata;
   assign unused_rdata = ^m.M_ReadData[31:24];

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      cnt_d    = cnt_q;
      sample_d = sample_q;
      result_d = result_q;
      settle_d = settle_q;

      case (state_q)
         IDLE: begin
            if (Start) begin
               src_d   = SrcAddr;
               dst_d   = DstAddr;
               cnt_d   = Count;
               state_d = (Count == '0) ? DONE : RD_SRC;
            end
         end
         RD_SRC: begin
            if (!m.M_WaitRequest) begin
               sample_d = m.M_ReadData[7:0];
               state_d  = WR_X;
            end
         end
         WR_X: begin
            if (!m.M_WaitRequest) begin
               settle_d = SETTLE_LOAD;
               state_d  = (FIR_LAT == 0) ? RD_Y : SETTLE;
            end
         end
         SETTLE: begin
            if (settle_q == 4'd0) begin
               state_d = RD_Y;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         RD_Y: begin
            if (!m.M_WaitRequest) begin
               result_d = m.M_ReadData[23:0];
               state_d  = WR_DST;
            end
         end
         WR_DST: begin
            if (!m.M_WaitRequest) begin
               src_d   = src_q + ADDR_W'(4);
               dst_d   = dst_q + ADDR_W'(4);
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q == CNT_W'(1)) ? DONE : RD_SRC;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus request for the next state is registered, so it is stable while stalled.
   always_comb begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      case (state_d)
         RD_SRC: begin
            rd_d   = 1'b1;
            addr_d = src_d;
         end
         WR_X: begin
            wr_d    = 1'b1;
            addr_d  = FIR_X_ADDR;
            wdata_d = {24'b0, sample_d};
         end
         RD_Y: begin
            rd_d   = 1'b1;
            addr_d = FIR_Y_ADDR;
         end
         WR_DST: begin
            wr_d    = 1'b1;
            addr_d  = dst_d;
            wdata_d = {8'b0, result_d};
         end
         default: ;
      endcase
   end

   // Status lags the state by one cycle: Done lands 5N+1 edges after Start.
   assign busy_d = (state_q != IDLE) && (state_q != DONE);
   assign done_d = (state_q == DONE);

   // NOTE: sequential state uses non-blocking assignments so every register updates together.
   always_ff @(posedge clk or negedge RstN) begin
      if (!RstN) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         cnt_q    <= '0;
         sample_q <= '0;
         result_q <= '0;
         settle_q <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
         result_q <= result_d;
         settle_q <= settle_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign m.M_Read      = rd_q;
   assign m.M_Write     = wr_q;
   assign m.M_Address   = addr_q;
   assign m.M_WriteData = wdata_q;
   assign Busy          = busy_q;
   assign Done          = done_q;

`ifdef FIR_DMA_IRQ_EN
   logic irq_q;

   // Set wins over clear when both land on the same edge.
   always_ff @(posedge clk or negedge RstN) begin
      if (!RstN) begin
         irq_q <= 1'b0;
      end else if (state_q == DONE) begin
         irq_q <= 1'b1;
      end else if (IrqClear) begin
         irq_q <= 1'b0;
      end
   end

   assign Irq = irq_q;
`endif

endmodule

// File: tb/tb_fir_dma_master.sv
// Randomized self-checking bench for fir_dma_master: memory + stub FIR slave
// (Yn = 2*X) with random wait states, checked against a per-sample reference model.
module tb_fir_dma_master;

   localparam logic [31:0] FIR_X = 32'h0000_1004;
   localparam logic [31:0] FIR_Y = 32'h0000_1008;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } op_t;

   logic        clk;
   logic        RstN;
   logic        Start;
   logic [31:0] SrcAddr;
   logic [31:0] DstAddr;
   logic [15:0] Count;
   logic        Busy;
   logic        Done;
`ifdef FIR_DMA_IRQ_EN
   logic        irq;
   logic        irq_clear;
`endif

   fir_dma_master_if #(.ADDR_W(32)) bus_if ();

   fir_dma_master dut (
      .clk     (clk),
      .RstN    (RstN),
      .Start   (Start),
      .SrcAddr (SrcAddr),
      .DstAddr (DstAddr),
      .Count   (Count),
      .Busy    (Busy),
      .Done    (Done),
      .m       (bus_if.master)
`ifdef FIR_DMA_IRQ_EN
      ,
      .Irq     (irq),
      .IrqClear(irq_clear)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory + FIR stub slave, evaluated on the falling edge.
   logic [31:0] mem [logic [31:0]];
   op_t         ops[$];
   logic [7:0]  fir_x;
   int          max_stall_g = 0;
   int          stall;
   bit          in_txn;
   logic [31:0] t_addr, t_data;
   logic        t_rd, t_wr;
   int          stab_viol = 0;
   int          overlap_viol = 0;

   always @(negedge clk) begin
      logic [31:0] rnd;
      logic [31:0] a;
      rnd = $urandom;
      a   = bus_if.M_Address;
      if (!RstN) begin
         in_txn                = 1'b0;
         stall                 = 0;
         bus_if.M_WaitRequest  = 1'b0;
         bus_if.M_ReadData     = 32'h0;
      end else begin
         if (bus_if.M_Read && bus_if.M_Write) overlap_viol++;
         if (bus_if.M_Read || bus_if.M_Write) begin
            if (!in_txn) begin
               in_txn = 1'b1;
               stall  = $urandom_range(0, max_stall_g);
               t_addr = a;
               t_data = bus_if.M_WriteData;
               t_rd   = bus_if.M_Read;
               t_wr   = bus_if.M_Write;
            end else if (t_addr !== a || t_data !== bus_if.M_WriteData ||
                         t_rd !== bus_if.M_Read || t_wr !== bus_if.M_Write) begin
               stab_viol++;
            end
            if (stall > 0) begin
               stall--;
               bus_if.M_WaitRequest = 1'b1;
               bus_if.M_ReadData    = rnd;
            end else begin
               bus_if.M_WaitRequest = 1'b0;
               in_txn               = 1'b0;
               if (bus_if.M_Read) begin
                  if (a == FIR_Y) bus_if.M_ReadData = {rnd[31:24], 15'h0, fir_x, 1'b0};
                  else if (mem.exists(a)) bus_if.M_ReadData = mem[a];
                  else bus_if.M_ReadData = rnd;
                  ops.push_back('{wr: 1'b0, addr: a, data: 32'h0});
               end else begin
                  if (a == FIR_X) fir_x = bus_if.M_WriteData[7:0];
                  else mem[a] = bus_if.M_WriteData;
                  ops.push_back('{wr: 1'b1, addr: a, data: bus_if.M_WriteData});
               end
            end
         end else begin
            bus_if.M_WaitRequest = rnd[0];
            bus_if.M_ReadData    = rnd;
         end
      end
   end

   // One full transfer: model, stimulus, then comparison of bus trace and memory.
   task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int n,
                           input int max_stall, input bit timed, input bit poke,
                           input bit clr_at_done);
      op_t         exp_ops[$];
      logic [31:0] exp_mem[$];
      logic [7:0]  x;
      int          e, busy_cnt, limit, extra;

      for (int i = 0; i < n; i++) begin
         x = mem[src + 32'(4 * i)][7:0];
         exp_ops.push_back('{wr: 1'b0, addr: src + 32'(4 * i), data: 32'h0});
         exp_ops.push_back('{wr: 1'b1, addr: FIR_X, data: {24'h0, x}});
         exp_ops.push_back('{wr: 1'b0, addr: FIR_Y, data: 32'h0});
         exp_ops.push_back('{wr: 1'b1, addr: dst + 32'(4 * i), data: 32'(x) * 2});
         exp_mem.push_back(32'(x) * 2);
         mem.delete(dst + 32'(4 * i));
      end
      max_stall_g  = max_stall;
      ops.delete();
      stab_viol    = 0;
      overlap_viol = 0;
      limit        = n * (5 + 4 * max_stall) + 10;

      @(negedge clk);
      Start   = 1'b1;
      SrcAddr = src;
      DstAddr = dst;
      Count   = 16'(n);
      @(negedge clk);
      Start   = 1'b0;
      SrcAddr = $urandom & 32'hFFFF_FFFC;
      DstAddr = $urandom & 32'hFFFF_FFFC;
      Count   = 16'($urandom);
      e        = 0;
      busy_cnt = 0;
      while (!Done && e < limit) begin
         if (poke && e == 2) begin
            Start   = 1'b1;
            SrcAddr = 32'h0000_3000;
            Count   = 16'd1;
         end
         if (poke && e == 3) Start = 1'b0;
         if (poke && timed && e == 5 * n) Start = 1'b1;
`ifdef FIR_DMA_IRQ_EN
         if (clr_at_done && e == 5 * n) irq_clear = 1'b1;
`endif
         @(negedge clk);
         e++;
         if (Busy) busy_cnt++;
      end
      Start = 1'b0;
`ifdef FIR_DMA_IRQ_EN
      irq_clear = 1'b0;
      check("irq_with_done", irq, 1'b1);
`else
      if (clr_at_done) Start = 1'b0;
`endif
      check("done_seen", Done, 1'b1);
      check("busy_at_done", Busy, 1'b0);
      if (timed) begin
         check("done_edge", e, 5 * n + 1);
         check("busy_cycles", busy_cnt, 5 * n);
      end
      @(negedge clk);
      check("done_width", Done, 1'b0);
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (Done || Busy) extra++;
      end
      check("idle_after", extra, 0);

      check("op_count", ops.size(), exp_ops.size());
      for (int i = 0; i < exp_ops.size() && i < ops.size(); i++)
         check($sformatf("op%0d", i), ops[i], exp_ops[i]);
      for (int i = 0; i < n; i++)
         check($sformatf("dst%0d", i), mem[dst + 32'(4 * i)], exp_mem[i]);
      check("rd_wr_overlap", overlap_viol, 0);
      if (max_stall > 0) check("stall_stable", stab_viol, 0);
   endtask

   task automatic reset_mid_transfer();
      int wrx, e, dones;
      for (int i = 0; i < 3; i++) mem[32'h300 + 32'(4 * i)] = $urandom;
      max_stall_g = 0;
      @(negedge clk);
      Start   = 1'b1;
      SrcAddr = 32'h300;
      DstAddr = 32'h500;
      Count   = 16'd3;
      @(negedge clk);
      Start = 1'b0;
      wrx   = 0;
      e     = 0;
      while (wrx < 2 && e < 100) begin
         @(negedge clk);
         e++;
         if (bus_if.M_Write && bus_if.M_Address == FIR_X) wrx++;
      end
      check("wrx_reached", wrx, 2);
      #2 RstN = 1'b0;
      #1;
      check("rst_ctrl", {Busy, Done, bus_if.M_Read, bus_if.M_Write}, 4'b0);
      check("rst_bus", {bus_if.M_Address, bus_if.M_WriteData}, 64'h0);
`ifdef FIR_DMA_IRQ_EN
      check("rst_irq", irq, 1'b0);
`endif
      repeat (2) @(negedge clk);
      #2 RstN = 1'b1;
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (Done || Busy) dones++;
      end
      check("no_done_after_abort", dones, 0);
      mem[32'h600] = $urandom;
      run_xfer(32'h600, 32'h700, 1, 0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] src, dst;
      int          n, ms;

      RstN    = 1'b0;
      Start   = 1'b0;
      SrcAddr = 32'h0;
      DstAddr = 32'h0;
      Count   = 16'h0;
`ifdef FIR_DMA_IRQ_EN
      irq_clear = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset_ctrl", {Busy, Done, bus_if.M_Read, bus_if.M_Write}, 4'b0);
      check("reset_bus", {bus_if.M_Address, bus_if.M_WriteData}, 64'h0);
`ifdef FIR_DMA_IRQ_EN
      check("reset_irq", irq, 1'b0);
`endif
      #2 RstN = 1'b1;
      @(negedge clk);

      // Basic transfer with known data.
      mem[32'h100] = 32'h05;
      mem[32'h104] = 32'h03;
      mem[32'h108] = 32'hFF;
      run_xfer(32'h100, 32'h200, 3, 0, 1'b1, 1'b0, 1'b0);
      check("basic_w0", mem[32'h200], 32'h0A);
      check("basic_w1", mem[32'h204], 32'h06);
      check("basic_w2", mem[32'h208], 32'h1FE);

      // Same buffer under random stalls on every transaction.
      run_xfer(32'h100, 32'h200, 3, 3, 1'b0, 1'b0, 1'b0);

      // Random buffers; the first one wraps the source pointer past 2^32.
      for (int it = 0; it < 4; it++) begin
         src = (it == 0) ? 32'hFFFF_FFF8 : 32'h2000 + 32'($urandom_range(0, 200) * 4);
         dst = 32'h4000 + 32'($urandom_range(0, 200) * 4);
         n   = (it == 0) ? 4 : $urandom_range(1, 6);
         ms  = $urandom_range(0, 2);
         for (int i = 0; i < n; i++) mem[src + 32'(4 * i)] = $urandom;
         run_xfer(src, dst, n, ms, ms == 0, 1'b0, 1'b0);
      end

      // Count=0: immediate Done, no traffic, Busy never rises.
      run_xfer(32'h100, 32'h900, 0, 0, 1'b1, 1'b0, 1'b0);

      // Start while busy and Start in the DONE cycle are both dropped.
      run_xfer(32'h100, 32'hA00, 3, 0, 1'b1, 1'b1, 1'b0);

      reset_mid_transfer();

`ifdef FIR_DMA_IRQ_EN
      check("irq_sticky", irq, 1'b1);
      @(negedge clk);
      irq_clear = 1'b1;
      @(negedge clk);
      irq_clear = 1'b0;
      check("irq_cleared", irq, 1'b0);
      mem[32'h800] = $urandom;
      run_xfer(32'h800, 32'hB00, 1, 0, 1'b1, 1'b0, 1'b1);
      check("irq_set_wins", irq, 1'b1);
      irq_clear = 1'b1;
      @(negedge clk);
      irq_clear = 1'b0;
      check("irq_cleared2", irq, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
